// File: rtl/lcd_win_stats.sv
// lcd_win_stats
//
// Collects 3x3 windows (9 consecutive accepted pixels) from the LCD
// controller's pixel output stream. For each window it computes the sum,
// maximum, minimum, and the arrival index of the first maximum. It
// optionally computes the mean. One result per window is presented on a
// valid/ready result slot.
//
// Optional feature: define WIN_MEAN_EN to build the floor(sum/9) datapath.
// Without it, res_mean is tied to 0.
//
// Handshake: a result is transferred on any rising edge where
// res_valid && res_ready. While res_valid is 1, the res_* fields are stable
// until that transfer. An exception is a new window completing on the very
// cycle of a transfer: the new window then replaces the old one and
// res_valid stays 1.
//
// Ports
//   clk, reset        : clock; asynchronous active-high reset
//   pix_in[7:0]       : pixel byte (controller dataout)
//   pix_valid         : pix_in valid this cycle (controller output_valid)
//   res_ready         : consumer accepts the result this cycle
//   res_valid         : result slot holds an unconsumed window result
//   res_sum[11:0]     : sum of the 9 pixels
//   res_max/res_min   : largest / smallest pixel
//   res_maxidx[3:0]   : arrival index (0..8) of the first maximum
//   res_mean[7:0]     : floor(sum/9) (WIN_MEAN_EN only, else 0)
//   collecting        : a partial window is held (collector state == ACC)
//   frag_err          : one-cycle pulse, partial window aborted by a gap
//   ovf               : one-cycle pulse, completed window dropped
//   win_cnt[CNT_W-1:0]: completed windows loaded into the slot; wraps
module lcd_win_stats #(
  parameter int GAP_MAX = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       pix_in,
  input  logic             pix_valid,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [11:0]      res_sum,
  output logic [7:0]       res_max,
  output logic [7:0]       res_min,
  output logic [3:0]       res_maxidx,
  output logic [7:0]       res_mean,
  output logic             collecting,
  output logic             frag_err,
  output logic             ovf,
  output logic [CNT_W-1:0] win_cnt
);

  localparam int GW = $clog2(GAP_MAX) + 1;
  // gap_cnt value seen during the last tolerated idle cycle; one more idle
  // cycle makes GAP_MAX and aborts the window.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      acc_sum_q, acc_sum_d;
  logic [7:0]       acc_max_q, acc_max_d;
  logic [7:0]       acc_min_q, acc_min_d;
  logic [3:0]       acc_idx_q, acc_idx_d;
  logic [3:0]       smp_cnt_q, smp_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             frag_q, frag_d;
  logic             ovf_q, ovf_d;

  logic             res_valid_q, res_valid_d;
  logic [11:0]      res_sum_q;
  logic [7:0]       res_max_q;
  logic [7:0]       res_min_q;
  logic [3:0]       res_idx_q;
  logic [CNT_W-1:0] win_cnt_q;

  // Running values merged with the current sample. These are the next
  // accumulator contents for samples 2..8. They are the final window
  // values on the 9th sample.
  logic        take_max;
  logic [11:0] fin_sum;
  logic [7:0]  fin_max;
  logic [7:0]  fin_min;
  logic [3:0]  fin_idx;
  logic        win_done;
  logic        slot_free;
  logic        load;

  // Strict compare keeps the first occurrence of the maximum.
  assign take_max  = pix_in > acc_max_q;
  assign fin_sum   = acc_sum_q + {4'd0, pix_in};
  assign fin_max   = take_max ? pix_in : acc_max_q;
  assign fin_min   = (pix_in < acc_min_q) ? pix_in : acc_min_q;
  // smp_cnt_q equals the arrival index of the current sample.
  assign fin_idx   = take_max ? smp_cnt_q : acc_idx_q;

  assign win_done  = (state_q == S_ACC) && pix_valid && (smp_cnt_q == 4'd8);
  // The slot can take a new window if it is empty or is draining this cycle.
  assign slot_free = !res_valid_q || res_ready;
  assign load      = win_done && slot_free;

  // Collector next state and running registers
  always_comb begin
    state_d   = state_q;
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    acc_idx_d = acc_idx_q;
    smp_cnt_d = smp_cnt_q;
    gap_cnt_d = gap_cnt_q;
    frag_d    = 1'b0;
    ovf_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pix_valid) begin
          state_d   = S_ACC;
          acc_sum_d = {4'd0, pix_in};
          acc_max_d = pix_in;
          acc_min_d = pix_in;
          acc_idx_d = 4'd0;
          smp_cnt_d = 4'd1;
          gap_cnt_d = '0;
        end
      end
      S_ACC: begin
        if (pix_valid) begin
          gap_cnt_d = '0;
          if (smp_cnt_q == 4'd8) begin
            state_d   = S_IDLE;
            acc_sum_d = '0;
            acc_max_d = '0;
            acc_min_d = '0;
            acc_idx_d = '0;
            smp_cnt_d = '0;
            ovf_d     = !slot_free;
          end else begin
            acc_sum_d = fin_sum;
            acc_max_d = fin_max;
            acc_min_d = fin_min;
            acc_idx_d = fin_idx;
            smp_cnt_d = smp_cnt_q + 4'd1;
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          acc_sum_d = '0;
          acc_max_d = '0;
          acc_min_d = '0;
          acc_idx_d = '0;
          smp_cnt_d = '0;
          gap_cnt_d = '0;
          frag_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result slot occupancy
  always_comb begin
    res_valid_d = res_valid_q;
    if (load) begin
      res_valid_d = 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_min_q   <= '0;
      acc_idx_q   <= '0;
      smp_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frag_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_max_q   <= '0;
      res_min_q   <= '0;
      res_idx_q   <= '0;
      win_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      acc_min_q   <= acc_min_d;
      acc_idx_q   <= acc_idx_d;
      smp_cnt_q   <= smp_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frag_q      <= frag_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      if (load) begin
        res_sum_q <= fin_sum;
        res_max_q <= fin_max;
        res_min_q <= fin_min;
        res_idx_q <= fin_idx;
        win_cnt_q <= win_cnt_q + 1'b1;
      end
    end
  end

`ifdef WIN_MEAN_EN
  // floor(sum/9) as (sum * 7282) >> 16. This is exact for sum <= 2295.
  logic [7:0] fin_mean;
  logic [7:0] res_mean_q;

  assign fin_mean = 8'(({13'd0, fin_sum} * 25'd7282) >> 16);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_mean_q <= '0;
    end else if (load) begin
      res_mean_q <= fin_mean;
    end
  end

  assign res_mean = res_mean_q;
`else
  assign res_mean = 8'd0;
`endif

  assign res_valid  = res_valid_q;
  assign res_sum    = res_sum_q;
  assign res_max    = res_max_q;
  assign res_min    = res_min_q;
  assign res_maxidx = res_idx_q;
  assign collecting = (state_q == S_ACC);
  assign frag_err   = frag_q;
  assign ovf        = ovf_q;
  assign win_cnt    = win_cnt_q;

endmodule

// File: tb/tb_lcd_win_stats.sv
// Testbench for lcd_win_stats. It applies directed scenarios followed by
// random traffic. A reference model built from queues predicts the result
// slot contents. That model stores each window's 9 pixels and then
// computes the statistics over them.
module tb_lcd_win_stats;

  localparam int GAP_MAX = 4;
  localparam int CNT_W   = 16;
`ifdef WIN_MEAN_EN
  localparam bit MEAN_ON = 1'b1;
`else
  localparam bit MEAN_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [7:0]       pix_in;
  logic             pix_valid;
  logic             res_ready;
  logic             res_valid;
  logic [11:0]      res_sum;
  logic [7:0]       res_max;
  logic [7:0]       res_min;
  logic [3:0]       res_maxidx;
  logic [7:0]       res_mean;
  logic             collecting;
  logic             frag_err;
  logic             ovf;
  logic [CNT_W-1:0] win_cnt;

  lcd_win_stats #(.GAP_MAX(GAP_MAX), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_max    (res_max),
    .res_min    (res_min),
    .res_maxidx (res_maxidx),
    .res_mean   (res_mean),
    .collecting (collecting),
    .frag_err   (frag_err),
    .ovf        (ovf),
    .win_cnt    (win_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  // Packed result: {sum[11:0], max[7:0], min[7:0], idx[3:0], mean[7:0]}
  logic [39:0]      exp_q[$];   // result slot contents (0 or 1 entry)
  logic [7:0]       win_q[$];   // pixels of the window being collected
  int               idle_run;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_frag;
  logic             exp_ovf;
  int               n_pass;
  int               n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [39:0] window_stats();
    int sum;
    int mx;
    int mn;
    int ix;
    int mean;
    sum = 0;
    mx  = int'(win_q[0]);
    mn  = int'(win_q[0]);
    ix  = 0;
    foreach (win_q[i]) begin
      sum += int'(win_q[i]);
      if (int'(win_q[i]) > mx) begin
        mx = int'(win_q[i]);
        ix = i;
      end
      if (int'(win_q[i]) < mn) mn = int'(win_q[i]);
    end
    mean = MEAN_ON ? sum / 9 : 0;
    return {12'(sum), 8'(mx), 8'(mn), 4'(ix), 8'(mean)};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    win_q.delete();
    idle_run = 0;
    exp_cnt  = '0;
    exp_frag = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("res_valid",  {63'd0, res_valid},  {63'd0, exp_q.size() > 0});
    chk("collecting", {63'd0, collecting}, {63'd0, win_q.size() > 0});
    chk("frag_err",   {63'd0, frag_err},   {63'd0, exp_frag});
    chk("ovf",        {63'd0, ovf},        {63'd0, exp_ovf});
    chk("win_cnt",    64'(win_cnt),        64'(exp_cnt));
    if (exp_q.size() > 0)
      chk("result", 64'({res_sum, res_max, res_min, res_maxidx, res_mean}), 64'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic step(input logic v, input logic [7:0] p, input logic r);
    logic        done;
    logic [39:0] res;
    pix_valid = v;
    pix_in    = p;
    res_ready = r;
    exp_frag  = 1'b0;
    exp_ovf   = 1'b0;
    done      = 1'b0;
    res       = '0;
    if (v) begin
      win_q.push_back(p);
      idle_run = 0;
      if (win_q.size() == 9) begin
        res  = window_stats();
        done = 1'b1;
        win_q.delete();
      end
    end else if (win_q.size() > 0) begin
      idle_run++;
      if (idle_run == GAP_MAX) begin
        exp_frag = 1'b1;
        win_q.delete();
        idle_run = 0;
      end
    end
    if (done) begin
      if (exp_q.size() == 0 || r) begin
        exp_q.delete();
        exp_q.push_back(res);
        exp_cnt++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else if (exp_q.size() > 0 && r) begin
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    res_ready = 1'b1;
    model_clear();
    #1;
    // The reset is asynchronous, so outputs must clear before any edge.
    chk("rst_valid",  64'(res_valid),  64'd0);
    chk("rst_sum",    64'(res_sum),    64'd0);
    chk("rst_max",    64'(res_max),    64'd0);
    chk("rst_min",    64'(res_min),    64'd0);
    chk("rst_idx",    64'(res_maxidx), 64'd0);
    chk("rst_mean",   64'(res_mean),   64'd0);
    chk("rst_coll",   64'(collecting), 64'd0);
    chk("rst_frag",   64'(frag_err),   64'd0);
    chk("rst_ovf",    64'(ovf),        64'd0);
    chk("rst_wincnt", 64'(win_cnt),    64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_window(input logic [7:0] base, input logic r);
    for (int i = 0; i < 9; i++) step(1'b1, base + 8'(i * 3), r);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] tie_pix [9];
    logic [39:0] third;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    res_ready = 1'b1;
    #2;
    do_reset();

    // Contiguous burst 10..90
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(i * 10), 1'b1);
    chk("burst_sum",  64'(res_sum),    64'd450);
    chk("burst_max",  64'(res_max),    64'd90);
    chk("burst_min",  64'(res_min),    64'd10);
    chk("burst_idx",  64'(res_maxidx), 64'd8);
    chk("burst_mean", 64'(res_mean),   MEAN_ON ? 64'd50 : 64'd0);
    chk("burst_cnt",  64'(win_cnt),    64'd1);
    step(1'b0, 8'd0, 1'b1);

    // Tie on maximum
    tie_pix = '{8'd7, 8'd200, 8'd3, 8'd200, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    foreach (tie_pix[i]) step(1'b1, tie_pix[i], 1'b1);
    chk("tie_max",  64'(res_max),    64'd200);
    chk("tie_idx",  64'(res_maxidx), 64'd1);
    chk("tie_min",  64'(res_min),    64'd3);
    chk("tie_sum",  64'(res_sum),    64'd455);
    chk("tie_mean", 64'(res_mean),   MEAN_ON ? 64'd50 : 64'd0);
    step(1'b0, 8'd0, 1'b1);

    // A gap one shorter than GAP_MAX keeps the window
    for (int i = 0; i < 4; i++) step(1'b1, 8'(40 + i), 1'b1);
    for (int i = 0; i < GAP_MAX - 1; i++) step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'd255, 1'b1);
    chk("gap_ok_valid", 64'(res_valid), 64'd1);
    chk("gap_ok_sum",   64'(res_sum),   64'(40 + 41 + 42 + 43 + 5 * 255));
    step(1'b0, 8'd0, 1'b1);

    // A gap of GAP_MAX aborts the window
    for (int i = 0; i < 4; i++) step(1'b1, 8'(60 + i), 1'b1);
    for (int i = 0; i < GAP_MAX; i++) step(1'b0, 8'd0, 1'b1);
    chk("abort_frag", 64'(frag_err),   64'd1);
    chk("abort_coll", 64'(collecting), 64'd0);
    step(1'b0, 8'd0, 1'b1);
    send_window(8'd100, 1'b1);
    chk("fresh_sum", 64'(res_sum), 64'(9 * 100 + 3 * 36));
    step(1'b0, 8'd0, 1'b1);

    // Backpressure: two windows held off, then reuse on handshake
    do_reset();
    send_window(8'd1, 1'b0);
    send_window(8'd50, 1'b0);
    chk("bp_ovf",     64'(ovf),     64'd1);
    chk("bp_cnt",     64'(win_cnt), 64'd1);
    chk("bp_held",    64'(res_sum), 64'(9 * 1 + 3 * 36));
    for (int i = 0; i < 8; i++) step(1'b1, 8'(200 + i), 1'b0);
    step(1'b1, 8'd250, 1'b1);
    third = {12'(200 + 201 + 202 + 203 + 204 + 205 + 206 + 207 + 250), 8'd250, 8'd200, 4'd8,
             MEAN_ON ? 8'((200 + 201 + 202 + 203 + 204 + 205 + 206 + 207 + 250) / 9) : 8'd0};
    chk("reuse_valid", 64'(res_valid), 64'd1);
    chk("reuse_ovf",   64'(ovf),       64'd0);
    chk("reuse_cnt",   64'(win_cnt),   64'd2);
    chk("reuse_data",  64'({res_sum, res_max, res_min, res_maxidx, res_mean}), 64'(third));
    step(1'b0, 8'd0, 1'b1);

    // Reset mid-window
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 1'b1);
    do_reset();
    send_window(8'd20, 1'b1);
    chk("post_rst_cnt", 64'(win_cnt), 64'd1);
    chk("post_rst_sum", 64'(res_sum), 64'(9 * 20 + 3 * 36));

    // Random traffic: gaps of random length, extreme pixels, random ready
    for (int i = 0; i < 600; i++) begin
      logic       v;
      logic [7:0] p;
      logic       r;
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       p = 8'd0;
        1:       p = 8'd255;
        default: p = 8'($urandom_range(0, 255));
      endcase
      r = ($urandom_range(0, 3) != 0);
      step(v, p, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
